// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: a single signed MAC walks NTAPS taps per accepted sample.
// Holds the sample delay line and a coefficient file that can be written while idle.
module fir_mac_sequencer #(
   parameter int unsigned NTAPS = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 16,
   parameter int unsigned AW    = 2,
   parameter int unsigned OW    = DW + CW + AW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [OW-1:0] m_data,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic signed [CW-1:0] coef_wdata,
   output logic                 busy
);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                state_q, state_d;
   logic signed [DW-1:0]  x_q [NTAPS];
   logic signed [CW-1:0]  h_q [NTAPS];
   logic signed [OW-1:0]  acc_q;
   logic signed [OW-1:0]  m_data_q;
   logic                  m_valid_q;
   logic [AW-1:0]         idx_q;

   logic                  accept;
   logic                  last_tap;
   logic                  addr_ok;
   logic                  coef_wr;
   logic signed [DW+CW-1:0] prod;
   logic signed [OW-1:0]  sum;

   assign last_tap = (idx_q == AW'(NTAPS - 1));
   assign addr_ok  = (32'(coef_addr) < NTAPS);
   // Writes are only honoured in IDLE; anything else is dropped.
   assign coef_wr  = coef_we && (state_q == StIdle) && addr_ok;

   // Full-precision signed product, sign-extended into the accumulator width.
   assign prod = x_q[idx_q] * h_q[idx_q];
   assign sum  = acc_q + OW'(prod);

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      busy    = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            s_ready = 1'b1;
            if (s_valid) begin
               accept  = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            busy = 1'b1;
            if (last_tap) begin
               state_d = StOut;
            end
         end
         StOut: begin
            busy = 1'b1;
            if (m_valid_q && m_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Delay line: x_q[0] is the newest sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAPS; k++) begin
            x_q[k] <= '0;
         end
      end else if (accept) begin
         x_q[0] <= s_data;
         for (int k = 1; k < NTAPS; k++) begin
            x_q[k] <= x_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAPS; k++) begin
            h_q[k] <= CW'(k + 1);
         end
      end else if (coef_wr) begin
         h_q[coef_addr] <= coef_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         idx_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            acc_q <= '0;
            idx_q <= '0;
         end
         if (state_q == StMac) begin
            acc_q <= sum;
            idx_q <= last_tap ? '0 : idx_q + 1'b1;
            if (last_tap) begin
               m_data_q  <= sum;
               m_valid_q <= 1'b1;
            end
         end
         if ((state_q == StOut) && m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

endmodule
